// File: rtl/tbuart_pkg.sv
// Shared types and constants for the tbuart host-terminal UART.
// Both the TX FSM in the top and the RX sub-module use them.
package tbuart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;

endpackage

// File: rtl/tbuart_rx.sv
// 8N1 receiver: 2-flop synchroniser, mid-bit sampling FSM.
// A start that reads high at half a bit is dropped as a glitch.
module tbuart_rx
  import tbuart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4167
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ser_rx_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       rx_frame_err_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  logic          sync1_q, sync2_q, prev_q;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;

  // Bring the line into the clock domain; prev_q finds falling edges.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= ser_rx_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Receive state, counters and result registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Next state: half-bit start check, then full-bit sample spacing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    sh_d    = sh_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (prev_q && !sync2_q) state_d = START;
      end
      START: begin
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = sync2_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          sh_d  = {sync2_q, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'(DATA_BITS - 1)) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          data_d  = sh_q;
          valid_d = sync2_q;
          err_d   = !sync2_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_data_o      = data_q;
  assign rx_valid_o     = valid_q;
  assign rx_frame_err_o = err_q;

endmodule

// File: rtl/tbuart_core.sv
// Host-side 8N1 UART endpoint: edge-triggered transmitter plus
// an independent receiver, both at CLKS_PER_BIT clocks per bit.
module tbuart_core
  import tbuart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4167
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       ser_tx,
  output logic       tx_busy,
  output logic       tx_clear_req,
  input  logic       ser_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    data_q, data_d;
  logic          start_q;
  logic          ser_q, ser_d;
  logic          busy_q, busy_d;
  logic          clr_q, clr_d;

  // Transmit state and registered line/status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      start_q <= 1'b0;
      ser_q   <= 1'b1;
      busy_q  <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      start_q <= tx_start;
      ser_q   <= ser_d;
      busy_q  <= busy_d;
      clr_q   <= clr_d;
    end
  end

  // Next state: start only on a fresh tx_start edge while idle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    data_d  = data_q;
    ser_d   = ser_q;
    busy_d  = busy_q;
    clr_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (tx_start && !start_q) begin
          state_d = START;
          data_d  = tx_data;
          ser_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end
      START: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          ser_d   = data_q[0];
          state_d = DATA;
        end
      end
      DATA: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (idx_q == 3'(DATA_BITS - 1)) begin
            ser_d   = 1'b1;
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
            ser_d = data_q[idx_d];
          end
        end
      end
      STOP: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          clr_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ser_tx       = ser_q;
  assign tx_busy      = busy_q;
  assign tx_clear_req = clr_q;

  tbuart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk_i         (clock),
    .rst_i         (reset),
    .ser_rx_i      (ser_rx),
    .rx_data_o     (rx_data),
    .rx_valid_o    (rx_valid),
    .rx_frame_err_o(rx_frame_err)
  );

endmodule

// File: tb/tb_tbuart_core.sv
// Randomised bench for tbuart_core at 16 clocks per bit.
// Expected line levels come from the frame definition itself.
module tb_tbuart_core;
  import tbuart_pkg::*;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       ser_tx, tx_busy, tx_clear_req;
  logic       ser_rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, rx_frame_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_valid  = 0;
  int n_err    = 0;
  int evt_cyc  = 0;
  logic [7:0] exp_rx = 8'h00;

  tbuart_core #(.CLKS_PER_BIT(CPB)) dut (
    .clock       (clk),
    .reset       (reset),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .ser_tx      (ser_tx),
    .tx_busy     (tx_busy),
    .tx_clear_req(tx_clear_req),
    .ser_rx      (ser_rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_frame_err(rx_frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid) begin
      n_valid = n_valid + 1;
      evt_cyc = cyc;
    end
    if (rx_frame_err) begin
      n_err   = n_err + 1;
      evt_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Send one byte; tx_start stays high for `hold` cycles.
  task automatic tx_frame(input logic [7:0] d, input int hold);
    logic [FRAME_BITS-1:0] fr;
    int ok [FRAME_BITS];
    int n, busy_n, clr_n, clr_at, idle_bad;
    fr = {1'b1, d, 1'b0};
    n  = ((hold > FRAME_BITS * CPB) ? hold : FRAME_BITS * CPB) + 3 * CPB;
    foreach (ok[k]) ok[k] = 0;
    busy_n = 0; clr_n = 0; clr_at = -1; idle_bad = 0;
    @(negedge clk);
    tx_data  = d;
    tx_start = 1'b1;
    for (int t = 0; t < n; t++) begin
      @(negedge clk);
      if (t == hold - 1) tx_start = 1'b0;
      if (t < FRAME_BITS * CPB) begin
        if (ser_tx === fr[t / CPB]) ok[t / CPB]++;
      end else if (ser_tx !== 1'b1) begin
        idle_bad++;
      end
      if (tx_busy) busy_n++;
      if (tx_clear_req) begin
        clr_n++;
        clr_at = t;
      end
    end
    tx_start = 1'b0;
    for (int k = 0; k < FRAME_BITS; k++)
      check($sformatf("tx_bit%0d_d%02h", k, d), ok[k], CPB);
    check("tx_busy_cycles", busy_n, FRAME_BITS * CPB);
    check("tx_clear_count", clr_n, 1);
    check("tx_clear_time", clr_at, FRAME_BITS * CPB);
    check("tx_idle_after", idle_bad, 0);
  endtask

  // Drive one frame (or a low glitch if glitch > 0) onto ser_rx.
  task automatic rx_frame(input logic [7:0] d, input logic stop,
                          input int glitch);
    logic [FRAME_BITS-1:0] fr;
    int v0, e0, fc, lat;
    v0 = n_valid;
    e0 = n_err;
    fr = {stop, d, 1'b0};
    @(negedge clk);
    fc = cyc;
    if (glitch > 0) begin
      ser_rx = 1'b0;
      repeat (glitch) @(negedge clk);
      ser_rx = 1'b1;
      repeat (FRAME_BITS * CPB) @(negedge clk);
      check("rx_glitch_valid", n_valid - v0, 0);
      check("rx_glitch_err", n_err - e0, 0);
      check("rx_glitch_data", rx_data, exp_rx);
    end else begin
      for (int k = 0; k < FRAME_BITS; k++) begin
        ser_rx = fr[k];
        repeat (CPB) @(negedge clk);
      end
      ser_rx = 1'b1;
      repeat (2 * CPB) @(negedge clk);
      exp_rx = d;
      check($sformatf("rx_valid_d%02h", d), n_valid - v0, {31'b0, stop});
      check($sformatf("rx_err_d%02h", d), n_err - e0, {31'b0, !stop});
      check($sformatf("rx_data_d%02h", d), rx_data, exp_rx);
      lat = evt_cyc - fc;
      check("rx_latency", (lat >= (19 * CPB) / 2 + 1) &&
                          (lat <= (19 * CPB) / 2 + 3), 1);
    end
  endtask

  initial begin
    int busy_n, clr_n, ser_bad;
    logic [7:0] a, b;
    logic st;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_ser_tx", ser_tx, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_clear", tx_clear_req, 0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_err", rx_frame_err, 0);

    tx_frame(8'h3D, 1);
    tx_frame(8'h0A, 400);
    rx_frame(8'h55, 1'b1, 0);
    rx_frame(8'hAB, 1'b0, 0);
    rx_frame(8'h00, 1'b1, 4);

    // Reset in the middle of data bit 3.
    @(negedge clk);
    tx_data  = 8'h3D;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (4 * CPB + 3) @(negedge clk);
    check("mid_busy", tx_busy, 1);
    check("mid_bit3", ser_tx, 1);
    reset = 1'b1;
    @(negedge clk);
    reset  = 1'b0;
    exp_rx = 8'h00;
    check("abort_ser_tx", ser_tx, 1);
    check("abort_busy", tx_busy, 0);
    busy_n = 0; clr_n = 0; ser_bad = 0;
    for (int t = 0; t < 3 * CPB; t++) begin
      if (tx_clear_req) clr_n++;
      if (tx_busy) busy_n++;
      if (ser_tx !== 1'b1) ser_bad++;
      @(negedge clk);
    end
    check("abort_clear", clr_n, 0);
    check("abort_quiet", busy_n + ser_bad, 0);
    tx_frame(8'h3D, 1);

    // Random concurrent traffic in both directions.
    for (int i = 0; i < 6; i++) begin
      a  = 8'($urandom);
      b  = 8'($urandom);
      st = ($urandom_range(0, 3) != 0);
      fork
        tx_frame(a, int'($urandom_range(1, 300)));
        rx_frame(b, st, 0);
      join
      if ($urandom_range(0, 2) == 0)
        rx_frame(8'h00, 1'b1, int'($urandom_range(1, CPB / 2 - 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
